alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single combinational Alu between N_REQ requesters (e.g. integer pipe, address generator, branch-compare unit) using valid/ready handshakes.
- Round-robin arbitration picks one request per cycle, drives the Alu, and captures the result in a one-entry output register.
- The result is returned only to the requester that issued it.
- Fully pipelined: one operation per cycle when every response is drained immediately.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ID_W, 1, requester index width; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  in  1  system clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accepted this cycle (one-hot or zero).
- req_op  in  4*N_REQ  per-requester ALU opcode; slice i = [4i+3:4i].
- req_a  in  32*N_REQ  per-requester operand A.
- req_b  in  32*N_REQ  per-requester operand B.
- rsp_valid  out  N_REQ  response valid, one-hot to the owning requester.
- rsp_ready  in  N_REQ  per-requester response ready.
- rsp_data  out  32  result, shared by all requesters; qualified by rsp_valid.
- rsp_err  out  1  opcode was not a defined ALU op; qualified by rsp_valid.
- rsp_id  out  ID_W  index of the owning requester.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - rsp_valid=0, rsp_data=0, rsp_err=0, rsp_id=0.
  - Round-robin pointer last_grant = N_REQ-1, so requester 0 has first priority.
  - An in-flight result is discarded.
  - req_ready=0 during the reset cycle.
- States:
  - EMPTY: output register free.
  - FULL: result held, waiting for rsp_ready[rsp_id].
  - Encoded as a single out_full flag.
- Drain: drain = FULL & rsp_ready[rsp_id].
- Slot free: slot_free = EMPTY | drain. This gives same-cycle drain-and-refill, so throughput is 1/cycle.
- Arbitration (combinational):
  - When slot_free, search req_valid starting at last_grant+1 and wrapping modulo N_REQ; the first set bit wins.
  - req_ready = onehot(winner) if slot_free and any req_valid, else 0.
  - Handshake on req_valid[i] & req_ready[i].
  - req_ready never depends on req_op, req_a or req_b.
- Accept at edge t:
  - Alu is driven with the winner's op, a and b.
  - At edge t: rsp_data <= result, rsp_err <= illegal, rsp_id <= winner, out_full <= 1, last_grant <= winner.
  - rsp_valid is asserted from cycle t+1, so latency is exactly 1 cycle.
- Drain without new accept: out_full <= 0 and rsp_valid goes to 0. rsp_data and rsp_id hold their values, which are don't-care.
- FULL without rsp_ready[rsp_id]:
  - All outputs hold stable.
  - req_ready = 0 for everyone.
  - rsp_ready from non-owners is ignored.
- Fairness: last_grant updates only on an accept. Any requester held valid is granted within N_REQ accepts.
- Legal opcodes: 0000, 0001, 0100, 0110, 0111, 1001, 1010, 1011, 1100, 1101.
- Illegal opcodes: rsp_data forced to 0 and rsp_err=1; the Alu output is not used.
- Shift ops: only b[4:0] is meaningful for shift amount. The arbiter presents b unmodified; shift semantics are the Alu's responsibility.
- Requester stability: a requester must hold op, a and b stable while valid and not ready. The arbiter samples them only on the accept edge.
- rsp_valid = onehot(rsp_id) & {N_REQ{out_full}}.

Decomposition:
- Shared package/header alu_defs:
  - ALU_OP_ADD=4'b0000, ALU_OP_SUB=4'b0001, ALU_OP_SLL=4'b0100, ALU_OP_SRL=4'b0110, ALU_OP_SRA=4'b0111, ALU_OP_AND=4'b1001, ALU_OP_OR=4'b1010, ALU_OP_XOR=4'b1011, ALU_OP_SLTU=4'b1100, ALU_OP_SLT=4'b1101.
  - function alu_op_legal(op).
- Sub-modules:
  - Instantiate the existing Alu unchanged.
  - One new sub-module rr_arbiter (N_REQ, ID_W): inputs req, en, last; outputs grant_onehot, grant_id, any.
- Output register and state live in alu_arbiter.

Test Plan:
- Reset mid-FULL: accept req0 ADD 5+3, hold rsp_ready=0, assert reset one cycle → rsp_valid=0, rsp_data=0 next cycle. First post-reset grant with both valid goes to req0.
- Single request: req1 SUB a=10 b=3 with rsp_ready=1 → req_ready=2'b10 in cycle t; rsp_valid=2'b10, rsp_id=1, rsp_data=7 (or the Alu's defined result for op 0001), rsp_err=0 at t+1.
- Round-robin: both requesters valid for 4 cycles, rsp_ready all 1 → grants alternate 0,1,0,1. Responses arrive back-to-back with no bubble.
- Backpressure: result owned by req0 with rsp_ready[0]=0 for 3 cycles and req1 valid throughout → req_ready=0 for 3 cycles and rsp_data stable. On the drain cycle req_ready[1]=1 and req1's result appears next cycle. rsp_ready[1]=1 during the stall has no effect.
- Illegal op: req0 op=4'b0010 a=1 b=1 → rsp_err=1, rsp_data=0 at t+1. Next legal op XOR 0xF0F0_F0F0^0xFFFF_0000 → rsp_data=0x0F0F_F0F0, rsp_err=0.
- Compare ops: SLTU a=0xFFFF_FFFF b=1 → 0; SLT with the same operands → 1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encodings, output-register state type and opcode legality check
// for the arbitrated ALU slice.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'b0000,
        ALU_OP_SUB  = 4'b0001,
        ALU_OP_SLL  = 4'b0100,
        ALU_OP_SRL  = 4'b0110,
        ALU_OP_SRA  = 4'b0111,
        ALU_OP_AND  = 4'b1001,
        ALU_OP_OR   = 4'b1010,
        ALU_OP_XOR  = 4'b1011,
        ALU_OP_SLTU = 4'b1100,
        ALU_OP_SLT  = 4'b1101
    } alu_op_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic logic alu_op_legal(input logic [3:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA,
            ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_SLTU, ALU_OP_SLT: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared single-cycle combinational ALU; undefined opcodes produce zero.
// Only b[4:0] is used as the shift amount.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_OP_ADD:  result = a + b;
            ALU_OP_SUB:  result = a - b;
            ALU_OP_SLL:  result = a << b[4:0];
            ALU_OP_SRL:  result = a >> b[4:0];
            ALU_OP_SRA:  result = 32'($signed(a) >>> b[4:0]);
            ALU_OP_AND:  result = a & b;
            ALU_OP_OR:   result = a | b;
            ALU_OP_XOR:  result = a ^ b;
            ALU_OP_SLTU: result = {31'b0, (a < b)};
            ALU_OP_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past 'last',
// wrapping modulo N_REQ; the first set bit wins when en is high.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);

    always_comb begin
        int unsigned idx;
        logic        found;
        idx          = 0;
        found        = 1'b0;
        grant_onehot = '0;
        grant_id     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last) + k) % N_REQ;
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_id          = ID_W'(idx);
            end
        end
        any = en && found;
        if (!en) begin
            grant_onehot = '0;
            grant_id     = '0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ valid/ready requesters with round-robin arbitration
// and a one-entry result register returned only to the issuing requester.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [4*N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [ID_W-1:0]       rsp_id
);

    out_state_e        state;
    out_state_e        state_next;
    logic [ID_W-1:0]   last_grant;
    logic              out_full;
    logic              drain;
    logic              slot_free;
    logic              grant_any;
    logic [N_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]   grant_id;
    logic [3:0]        sel_op;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [31:0]       alu_result;
    logic              op_legal;

    assign out_full  = (state == OUT_FULL);
    assign drain     = out_full && rsp_ready[rsp_id];
    assign slot_free = !out_full || drain;

    // Reset gates the arbiter so no request is acknowledged in the reset cycle.
    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req          (req_valid),
        .en           (slot_free && !reset),
        .last         (last_grant),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id),
        .any          (grant_any)
    );

    assign req_ready = grant_onehot;

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_onehot[i]) begin
                sel_op = sel_op | req_op[4*i +: 4];
                sel_a  = sel_a  | req_a[32*i +: 32];
                sel_b  = sel_b  | req_b[32*i +: 32];
            end
        end
    end

    alu u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result)
    );

    assign op_legal = alu_op_legal(sel_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            OUT_EMPTY: begin
                if (grant_any) state_next = OUT_FULL;
            end
            OUT_FULL: begin
                if (grant_any)  state_next = OUT_FULL;
                else if (drain) state_next = OUT_EMPTY;
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rsp_id     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else if (grant_any) begin
            rsp_data   <= op_legal ? alu_result : '0;
            rsp_err    <= !op_legal;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = out_full && (rsp_id == ID_W'(i));
        end
    end

endmodule
